// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter
// among NREQ byte requesters, with a start watchdog.
//
// Ports:
//   clk, reset            - clock, async active-high reset
//   req, req_data         - per-requester request level and byte
//   gnt, done, err        - one-hot grant, success pulse, abort pulse
//   tx_data, tx_start     - byte and start level to the transmitter
//   tx_busy               - transmitter busy
//   tx_complete_flag      - transmitter completion flag
//   tx_complete_del_flag  - completion-flag clear to the transmitter
//   busy                  - arbiter not idle
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int START_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              tx_complete_flag,
    output logic              tx_complete_del_flag,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic [NREQ-1:0]   err_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              del_q;
    logic              busy_q;
    logic              tx_busy_last_q;
    logic [IW-1:0]     rr_q;
    logic [IW-1:0]     win_q;
    logic [CW-1:0]     cnt_q;

    logic              pick_vld_d;
    logic [IW-1:0]     pick_idx_d;
    logic [7:0]        pick_byte_d;
    logic [IW-1:0]     rr_d;

    // Scan from the highest offset down so the set bit closest
    // to the rr pointer is the last one written and wins.
    always_comb begin
        int j;
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        j          = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = IW'(j);
            end
        end
    end

    assign pick_byte_d = req_data[{pick_idx_d, 3'b000} +: 8];

    // Pointer moves just past the winner so it is served last next time.
    assign rr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            gnt_q          <= '0;
            done_q         <= '0;
            err_q          <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            del_q          <= 1'b0;
            busy_q         <= 1'b0;
            tx_busy_last_q <= 1'b0;
            rr_q           <= '0;
            win_q          <= '0;
            cnt_q          <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            del_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        state_q        <= S_START;
                        win_q          <= pick_idx_d;
                        gnt_q          <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_d;
                        tx_data_q      <= pick_byte_d;
                        tx_start_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        cnt_q          <= '0;
                        tx_busy_last_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (tx_busy) begin
                        state_q        <= S_BUSY;
                        cnt_q          <= '0;
                        tx_busy_last_q <= 1'b1;
                    end else if (cnt_q == CW'(START_TIMEOUT)) begin
                        // Transmitter never acknowledged: abort.
                        state_q    <= S_IDLE;
                        tx_start_q <= 1'b0;
                        err_q      <= gnt_q;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        rr_q       <= rr_d;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BUSY: begin
                    tx_busy_last_q <= tx_busy;
                    if (tx_busy_last_q && !tx_busy) begin
                        state_q    <= S_DONE;
                        tx_start_q <= 1'b0;
                        done_q     <= gnt_q;
                        del_q      <= tx_complete_flag;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    rr_q    <= rr_d;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt                  = gnt_q;
    assign done                 = done_q;
    assign err                  = err_q;
    assign tx_data              = tx_data_q;
    assign tx_start             = tx_start_q;
    assign tx_complete_del_flag = del_q;
    assign busy                 = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (tx_data/tx_start/tx_busy/tx_complete_flag handshake) between NREQ independent byte requesters using round-robin arbitration.
- Latches the winner's byte, drives tx_start and holds it until the transmitter's tx_busy falling edge, then clears the completion flag and signals done back to the winner.
- Includes a start watchdog so a transmitter that never goes busy cannot hang the arbiter.
- Sits between the application-side byte sources and the UART transmitter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- START_TIMEOUT, 1023, max cycles in START waiting for tx_busy rise before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  level request per requester; held until its done pulse.
- req_data  input  8*NREQ  byte per requester, requester i at bits [8i+7:8i].
- gnt  output  NREQ  one-hot grant, high from grant until done/abort.
- done  output  NREQ  one-cycle pulse to the granted requester on successful send.
- err  output  NREQ  one-cycle pulse to the granted requester on watchdog abort.
- tx_data  output  8  byte to transmitter, stable while gnt nonzero.
- tx_start  output  1  start level to transmitter.
- tx_busy  input  1  transmitter busy.
- tx_complete_flag  input  1  transmitter completion flag.
- tx_complete_del_flag  output  1  completion-flag clear to transmitter.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, gnt=0, done=0, err=0, tx_data=0, tx_start=0, tx_complete_del_flag=0, busy=0, rr pointer=0, tx_busy_last=0.
- All outputs are registered.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr, rr+1, …, wrapping modulo NREQ.
  - Next cycle: gnt=onehot(winner), tx_data=req_data[winner], tx_start=1, busy=1, state=START.
  - Latency is 1 clock from req sampled to tx_start high.
- START:
  - tx_start held at 1; watchdog counter increments each cycle.
  - On tx_busy=1, go to BUSY and clear the counter.
  - If the counter reaches START_TIMEOUT with tx_busy still 0: tx_start=0, err pulse on the winner, gnt=0, rr=winner+1, state=IDLE.
- BUSY:
  - tx_start stays 1; tx_busy_last tracks tx_busy.
  - On the falling edge (tx_busy_last=1, tx_busy=0): tx_start=0, state=DONE.
- DONE (one cycle):
  - done pulse on the winner; tx_complete_del_flag=1 for this cycle if tx_complete_flag=1.
  - gnt=0, rr=(winner+1) mod NREQ, state=IDLE.
- Minimum back-to-back spacing: DONE→IDLE→START gives 2 idle cycles between bytes.
- A req change or deassertion after grant is ignored; the latched byte is always sent.
- req_data changes after grant do not affect tx_data.
- Simultaneous requests: exactly one grant per arbitration; no requester waits more than NREQ-1 transfers.
- Single requester held continuously: served every transfer (pointer wraps back to it).
- Never more than one gnt bit set; done and err are never both high; done and err are never raised for a non-granted index.
- Reset mid-transfer: tx_start drops immediately; no done is issued for the aborted byte.

Test Plan:
- Reset, then req=4'b0001, req_data[7:0]=8'hA5; tx_busy goes high 3 cycles after tx_start and low 100 cycles later -> tx_start high 1 clk after req, tx_data=8'hA5, gnt=0001, done[0] pulses 1 clk after tx_busy falls, tx_complete_del_flag=1 that cycle if tx_complete_flag=1.
- req=4'b1111 held, bytes 11/22/33/44 -> transmit order 11,22,33,44,11; each done pulse matches the gnt index.
- After a grant to requester 2, change req_data[23:16] from 8'h5A to 8'hFF and drop req[2] during BUSY -> tx_data stays 8'h5A and done[2] still pulses.
- tx_busy never asserts, START_TIMEOUT=15 -> tx_start high for 16 cycles, then err pulses on the winner, state returns to IDLE, and the next requester is served.
- Assert reset while in BUSY -> tx_start, gnt and busy go to 0 asynchronously with no done pulse; after release with req=0001, a normal transfer completes.
- Only req[3] asserted repeatedly with rr=0 -> granted each time, no idle starvation gap beyond 2 cycles between transfers.
